// File: rtl/data_memory_pkg.sv
// Shared sizing constants for the MEM-stage data memory.
// Words are addressed by byte address, so the low OFFSET_W bits are dropped.
package data_memory_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 1024;
    localparam int IDX_W    = 10;
    localparam int OFFSET_W = 2;

endpackage

// File: rtl/data_memory.sv
// Word-organised single-port data memory: synchronous write, combinational gated read.
// Latency: write lands at the rising Clk edge, read is zero-cycle; async Reset clears all words.
// Backpressure: none, every access completes in the cycle it is presented.
module data_memory #(
    parameter int DATA_W = data_memory_pkg::DATA_W,
    parameter int DEPTH  = data_memory_pkg::DEPTH,
    parameter int IDX_W  = data_memory_pkg::IDX_W
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic [data_memory_pkg::ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0]                 WriteData,
    input  logic                              MemWrite,
    input  logic                              MemRead,
    output logic [DATA_W-1:0]                 ReadData
);
    import data_memory_pkg::*;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  wordIdx;
    logic              unusedAddrBits;

    // Out-of-range addresses wrap because the upper bits are simply not decoded.
    assign wordIdx        = Address[IDX_W+OFFSET_W-1:OFFSET_W];
    assign unusedAddrBits = ^{Address[ADDR_W-1:IDX_W+OFFSET_W], Address[OFFSET_W-1:0]};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (MemWrite) begin
            mem[wordIdx] <= WriteData;
        end
    end

    // Reset gates the output directly so ReadData drops without waiting for the clear.
    always_comb begin
        ReadData = '0;
        if (MemRead && !Reset) begin
            ReadData = mem[wordIdx];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed, table-driven bench for data_memory plus hand sequences for reset and no-edge reads.
module tb_data_memory;

    logic        Clk;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;

    int tests;
    int failed;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [31:0] expRead;
    } vec_t;

    vec_t vecs[$];

    data_memory dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic re, input logic [31:0] expRead);
        vec_t v;
        v.name    = name;
        v.addr    = addr;
        v.wdata   = wdata;
        v.we      = we;
        v.re      = re;
        v.expRead = expRead;
        vecs.push_back(v);
    endtask

    // Drive one access in the low phase, check the pre-edge read, then clock it.
    task automatic applyVec(input vec_t v);
        @(negedge Clk);
        Address   = v.addr;
        WriteData = v.wdata;
        MemWrite  = v.we;
        MemRead   = v.re;
        #1;
        check(v.name, ReadData, v.expRead);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        Reset     = 1'b1;
        Address   = 32'h0;
        WriteData = 32'h0;
        MemWrite  = 1'b0;
        MemRead   = 1'b1;

        addVec("rst_rd_0x000", 32'h000, 32'h0, 1'b0, 1'b1, 32'h0);
        addVec("rst_rd_0x004", 32'h004, 32'h0, 1'b0, 1'b1, 32'h0);
        addVec("rst_rd_0xffc", 32'hFFC, 32'h0, 1'b0, 1'b1, 32'h0);
        addVec("wr_0x00",      32'h00, 32'h12345678, 1'b1, 1'b0, 32'h0);
        addVec("wr_0x04",      32'h04, 32'h0000FFFF, 1'b1, 1'b0, 32'h0);
        addVec("wr_0x08",      32'h08, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
        addVec("wr_0x16",      32'h16, 32'h0000000F, 1'b1, 1'b0, 32'h0);
        addVec("rd_0x00",      32'h00, 32'h0, 1'b0, 1'b1, 32'h12345678);
        addVec("rd_0x04",      32'h04, 32'h0, 1'b0, 1'b1, 32'h0000FFFF);
        addVec("rd_0x08",      32'h08, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF);
        addVec("rd_0x14",      32'h14, 32'h0, 1'b0, 1'b1, 32'h0000000F);
        addVec("rd_0x17",      32'h17, 32'h0, 1'b0, 1'b1, 32'h0000000F);
        addVec("rd_0x32",      32'h32, 32'h0, 1'b0, 1'b1, 32'h0);
        addVec("wr_0x10",      32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        addVec("wrdis_1",      32'h00, 32'hAAAAAAAA, 1'b0, 1'b1, 32'h12345678);
        addVec("wrdis_2",      32'h00, 32'hAAAAAAAA, 1'b0, 1'b1, 32'h12345678);
        addVec("wrdis_3",      32'h00, 32'hAAAAAAAA, 1'b0, 1'b1, 32'h12345678);
        addVec("wr_0x20_old",  32'h20, 32'h00000001, 1'b1, 1'b0, 32'h0);
        addVec("rw_0x20_pre",  32'h20, 32'h00000002, 1'b1, 1'b1, 32'h00000001);
        addVec("rd_0x20_post", 32'h20, 32'h0, 1'b0, 1'b1, 32'h00000002);
        addVec("wr_0x1000",    32'h1000, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
        addVec("rd_wrap_0x0",  32'h0000, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
        addVec("rd_wrap_hi",   32'hFFFF_F000, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);

        // Reset held: output must be zero even with MemRead low or high.
        @(negedge Clk);
        #1;
        check("rst_out_rd1", ReadData, 32'h0);
        MemRead = 1'b0;
        #1;
        check("rst_out_rd0", ReadData, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 13; i++) applyVec(vecs[i]);

        // Read gating with no clock edge between the two checks.
        applyVec(vecs[13]);
        @(negedge Clk);
        Address  = 32'h10;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        #1;
        check("gate_rd0", ReadData, 32'h0);
        MemRead = 1'b1;
        #1;
        check("gate_rd1", ReadData, 32'hDEADBEEF);

        for (int i = 14; i < 20; i++) applyVec(vecs[i]);

        // Simultaneous read/write: new data visible right after the edge.
        @(negedge Clk);
        Address   = 32'h20;
        WriteData = 32'h00000003;
        MemWrite  = 1'b1;
        MemRead   = 1'b1;
        #1;
        check("rw_pre_edge", ReadData, 32'h00000002);
        @(posedge Clk);
        #1;
        check("rw_post_edge", ReadData, 32'h00000003);

        for (int i = 20; i < 23; i++) applyVec(vecs[i]);

        // Async reset pulse entirely between clock edges.
        @(negedge Clk);
        Address  = 32'h0;
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        #1;
        check("pre_pulse", ReadData, 32'hCAFEF00D);
        Reset = 1'b1;
        #1;
        check("pulse_async", ReadData, 32'h0);
        #1;
        Reset = 1'b0;
        #1;
        check("post_pulse_0x0", ReadData, 32'h0);
        begin
            logic [31:0] addrs[7];
            addrs = '{32'h04, 32'h08, 32'h14, 32'h10, 32'h20, 32'h00, 32'h1000};
            for (int i = 0; i < 7; i++) begin
                Address = addrs[i];
                #1;
                check($sformatf("cleared_%h", addrs[i]), ReadData, 32'h0);
            end
        end

        // Write on an edge coincident with Reset is discarded.
        @(negedge Clk);
        Address   = 32'h40;
        WriteData = 32'h55555555;
        MemWrite  = 1'b1;
        MemRead   = 1'b1;
        Reset     = 1'b1;
        @(posedge Clk);
        #1;
        check("rst_wr_out", ReadData, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        MemWrite = 1'b0;
        #1;
        check("rst_wr_discard", ReadData, 32'h0);

        // First edge after release accepts a write.
        @(negedge Clk);
        MemWrite  = 1'b1;
        WriteData = 32'h0BADF00D;
        @(posedge Clk);
        #1;
        check("first_wr_after_rst", ReadData, 32'h0BADF00D);
        @(negedge Clk);
        MemWrite = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
